wb_nchan_client_decoder: RTL and testbench

- Parametrised N-channel Wishbone client decoder and interrupt aggregator between the AHB-to-FPGA bridge and NUM_CH peripheral instances (UARTs or similar), each occupying its own 4 KB aperture.
- Routes cycle strobes to the addressed channel and muxes read data and acknowledge back to the bridge.
- Terminates unmapped or hung accesses with a timed default ACK and DEFAULT_READ_VALUE, counting each such event.
- Packs per-channel interrupts onto the 4-bit FB_msg_out lines.

---
 rtl/wb_nchan_client_decoder_if.sv | 39 +++
 rtl/wb_nchan_client_decoder.sv | 195 +++++++++++++++++++
 tb/tb_wb_nchan_client_decoder.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_nchan_client_decoder_if.sv
// ---------------------------------------------------------------------------
// wb_nchan_client_decoder_if
//
// Bridge-side Wishbone bus between the AHB-to-FPGA bridge (master) and the
// N-channel client decoder (slave).
//
// Signals:
//   WBs_ADR     master -> slave  byte address (APERWIDTH bits)
//   WBs_CYC     master -> slave  cycle strobe
//   WBs_STB     master -> slave  transfer strobe
//   WBs_RD_DAT  slave  -> master read data (DATAWIDTH bits)
//   WBs_ACK     slave  -> master acknowledge
// ---------------------------------------------------------------------------
interface wb_nchan_client_decoder_if #(
    parameter int APERWIDTH = 17,
    parameter int DATAWIDTH = 32
);
    logic [APERWIDTH-1:0] WBs_ADR;
    logic                 WBs_CYC;
    logic                 WBs_STB;
    logic [DATAWIDTH-1:0] WBs_RD_DAT;
    logic                 WBs_ACK;

    modport master (
        output WBs_ADR,
        output WBs_CYC,
        output WBs_STB,
        input  WBs_RD_DAT,
        input  WBs_ACK
    );

    modport slave (
        input  WBs_ADR,
        input  WBs_CYC,
        input  WBs_STB,
        output WBs_RD_DAT,
        output WBs_ACK
    );
endinterface

// File: rtl/wb_nchan_client_decoder.sv
// ---------------------------------------------------------------------------
// wb_nchan_client_decoder
//
// Wishbone client decoder and interrupt aggregator sitting between the
// AHB-to-FPGA bridge and NUM_CH peripheral instances, each owning a
// 2**CH_APER_BITS byte aperture. The channel index is the address field
// above the aperture bits.
//
//  - Routes the cycle strobe to the addressed channel (one-hot Ch_CYC_o).
//  - Passes the selected client's ACK and read data straight back to the
//    bridge with zero latency.
//  - If no client answers within DEFAULT_CNTR_TIMEOUT+1 cycles (or the
//    address decodes to a channel that does not exist), the decoder issues
//    a one-cycle default ACK carrying DEFAULT_READ_VALUE so the bridge can
//    never hang. Each default ACK bumps a saturating 8-bit event counter.
//  - Folds the per-channel level interrupts onto NUM_MSG message lines:
//    channel i drives line i % NUM_MSG, registered once.
//
// Ports:
//   WB_CLK       in   fabric / Wishbone clock
//   WB_RST       in   synchronous active-high reset
//   wb           slave modport: WBs_ADR, WBs_CYC, WBs_STB in;
//                               WBs_RD_DAT, WBs_ACK out
//   Ch_CYC_o     out  per-channel cycle select (at most one bit set)
//   Ch_ACK_i     in   per-channel acknowledge
//   Ch_RD_DAT_i  in   packed per-channel read data, channel i at
//                     [i*DATAWIDTH +: DATAWIDTH]
//   Ch_Intr_i    in   per-channel level interrupt
//   FB_msg_out   out  aggregated interrupt lines
//   Tmo_Clr_i    in   clears the default-ACK event counter
//   Tmo_Cnt_o    out  saturating count of default-ACK events
// ---------------------------------------------------------------------------
module wb_nchan_client_decoder #(
    parameter int                   NUM_CH               = 4,
    parameter int                   APERWIDTH            = 17,
    parameter int                   CH_APER_BITS         = 12,
    parameter int                   DATAWIDTH            = 32,
    parameter logic [DATAWIDTH-1:0] DEFAULT_READ_VALUE   = 32'hBAD_FAB_AC,
    parameter int                   DEFAULT_CNTR_WIDTH   = 3,
    // Must stay below 2**DEFAULT_CNTR_WIDTH or the compare never matches.
    parameter int                   DEFAULT_CNTR_TIMEOUT = 7,
    parameter int                   NUM_MSG              = 4
) (
    input  logic                        WB_CLK,
    input  logic                        WB_RST,

    wb_nchan_client_decoder_if.slave    wb,

    output logic [NUM_CH-1:0]           Ch_CYC_o,
    input  logic [NUM_CH-1:0]           Ch_ACK_i,
    input  logic [NUM_CH*DATAWIDTH-1:0] Ch_RD_DAT_i,
    input  logic [NUM_CH-1:0]           Ch_Intr_i,

    output logic [NUM_MSG-1:0]          FB_msg_out,

    input  logic                        Tmo_Clr_i,
    output logic [7:0]                  Tmo_Cnt_o
);

    localparam int SEL_W = APERWIDTH - CH_APER_BITS;

    localparam logic [DEFAULT_CNTR_WIDTH-1:0] TMO_LAST =
        DEFAULT_CNTR_WIDTH'(DEFAULT_CNTR_TIMEOUT);

    // One extra bit so NUM_CH == 2**SEL_W still fits in the compare.
    localparam logic [SEL_W:0] NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic                 req;
    logic [SEL_W-1:0]     sel;
    logic                 mapped;
    logic                 cack;
    logic [DATAWIDTH-1:0] ch_rd_dat;

    // Register offsets inside an aperture belong to the client; the decoder
    // only needs the channel field.
    logic unused_offset_bits;
    assign unused_offset_bits = ^wb.WBs_ADR[CH_APER_BITS-1:0];

    assign req    = wb.WBs_CYC & wb.WBs_STB;
    assign sel    = wb.WBs_ADR[APERWIDTH-1:CH_APER_BITS];
    assign mapped = ({1'b0, sel} < NUM_CH_EXT);

    // Select the addressed client's ACK and read data. An unmapped sel
    // matches no channel, so cack stays 0 and the data falls back to the
    // default value -- no out-of-range indexing.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment; otherwise paths that skip the
        // assignment hold the old value and a latch is inferred.
        cack      = 1'b0;
        ch_rd_dat = DEFAULT_READ_VALUE;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                cack      = Ch_ACK_i[i];
                ch_rd_dat = Ch_RD_DAT_i[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Timeout timer and default acknowledge
    //
    // tmr counts request cycles without a client ACK. When it reaches
    // TMO_LAST with still no ACK, dflt_ack fires for exactly one cycle.
    // A client ACK in that same compare cycle wins, so the client's data is
    // never replaced by the default value.
    // -----------------------------------------------------------------------
    logic [DEFAULT_CNTR_WIDTH-1:0] tmr;
    logic                          dflt_ack;

    always_ff @(posedge WB_CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values; blocking here would let
        // later statements see already-updated state and create races.
        if (WB_RST) begin
            tmr      <= '0;
            dflt_ack <= 1'b0;
        end else begin
            dflt_ack <= req & ~cack & ~dflt_ack & (tmr == TMO_LAST);

            // Clearing on dflt_ack as well means a request still held after
            // any ACK starts a fresh access at tmr == 0.
            if (~req | cack | dflt_ack) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Bridge-side outputs
    //
    // During the default-ACK cycle the channel select is withdrawn and any
    // late client ACK is masked, so the bridge sees a single ACK. All
    // outputs are forced to their idle values while reset is held, which
    // also abandons an access in flight without an ACK.
    // -----------------------------------------------------------------------
    always_comb begin
        Ch_CYC_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            Ch_CYC_o[i] = req & mapped & (sel == SEL_W'(i)) & ~dflt_ack & ~WB_RST;
        end
    end

    assign wb.WBs_ACK    = ~WB_RST & ((req & cack & ~dflt_ack) | dflt_ack);
    assign wb.WBs_RD_DAT = (~WB_RST & mapped & ~dflt_ack) ? ch_rd_dat
                                                          : DEFAULT_READ_VALUE;

    // -----------------------------------------------------------------------
    // Default-ACK event counter
    //
    // Saturates at 255 rather than wrapping so software can tell "many" from
    // "few". A clear coinciding with an increment leaves 0: the clear is the
    // later software intent.
    // -----------------------------------------------------------------------
    always_ff @(posedge WB_CLK) begin
        if (WB_RST || Tmo_Clr_i) begin
            Tmo_Cnt_o <= 8'd0;
        end else if (dflt_ack && (Tmo_Cnt_o != 8'hFF)) begin
            Tmo_Cnt_o <= Tmo_Cnt_o + 8'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Interrupt aggregation
    //
    // Channel i feeds line i % NUM_MSG. Interrupts are levels: the output
    // follows the inputs one cycle later and nothing is latched.
    // -----------------------------------------------------------------------
    logic [NUM_MSG-1:0] msg_next;

    always_comb begin
        msg_next = '0;
        for (int k = 0; k < NUM_MSG; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((i % NUM_MSG) == k) begin
                    msg_next[k] = msg_next[k] | Ch_Intr_i[i];
                end
            end
        end
    end

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            FB_msg_out <= '0;
        end else begin
            FB_msg_out <= msg_next;
        end
    end

endmodule

// File: tb/tb_wb_nchan_client_decoder.sv
// ---------------------------------------------------------------------------
// tb_wb_nchan_client_decoder
//
// Self-checking bench for wb_nchan_client_decoder. Stimulus tasks compute
// the expected bridge-side response from the decoder's rules (client answers
// within the timeout window, otherwise a default ACK at TMO+1) and push it to
// a scoreboard; an independent monitor compares every WBs_ACK it observes.
// A second instance with six channels exercises interrupt folding.
// ---------------------------------------------------------------------------
module tb_wb_nchan_client_decoder;

    localparam int          NUM_CH = 4;
    localparam int          AW     = 17;
    localparam int          DW     = 32;
    localparam int          TMO    = 7;
    localparam logic [31:0] DEF    = 32'hBAD_FAB_AC;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main DUT (4 channels)
    wb_nchan_client_decoder_if #(.APERWIDTH(AW), .DATAWIDTH(DW)) wb ();
    logic [3:0]   ch_cyc;
    logic [3:0]   ch_ack;
    logic [127:0] ch_rd;
    logic [3:0]   ch_intr;
    logic [3:0]   fb;
    logic         tmo_clr;
    logic [7:0]   tmo_cnt;

    wb_nchan_client_decoder #(.NUM_CH(4)) dut (
        .WB_CLK      (clk),
        .WB_RST      (rst),
        .wb          (wb),
        .Ch_CYC_o    (ch_cyc),
        .Ch_ACK_i    (ch_ack),
        .Ch_RD_DAT_i (ch_rd),
        .Ch_Intr_i   (ch_intr),
        .FB_msg_out  (fb),
        .Tmo_Clr_i   (tmo_clr),
        .Tmo_Cnt_o   (tmo_cnt)
    );

    // Second DUT (6 channels), bus idle, used for interrupt folding
    wb_nchan_client_decoder_if #(.APERWIDTH(AW), .DATAWIDTH(DW)) wb6 ();
    logic [5:0]   cyc6;
    logic [5:0]   ack6;
    logic [191:0] rd6;
    logic [5:0]   intr6;
    logic [3:0]   fb6;
    logic         clr6;
    logic [7:0]   tmo6;

    wb_nchan_client_decoder #(.NUM_CH(6)) dut6 (
        .WB_CLK      (clk),
        .WB_RST      (rst),
        .wb          (wb6),
        .Ch_CYC_o    (cyc6),
        .Ch_ACK_i    (ack6),
        .Ch_RD_DAT_i (rd6),
        .Ch_Intr_i   (intr6),
        .FB_msg_out  (fb6),
        .Tmo_Clr_i   (clr6),
        .Tmo_Cnt_o   (tmo6)
    );

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned cyc_cnt  = 0;
    int          tmo_model = 0;
    logic [3:0]  fb_model4 = '0;
    logic [3:0]  fb_model6 = '0;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    endtask

    // -----------------------------------------------------------------------
    // Monitor: every ACK must match the head of the scoreboard, and no
    // expected ACK may be skipped.
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (wb.WBs_ACK === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ack: got ACK at cycle %0d, expected none", cyc_cnt);
            end else begin
                e = sb_q.pop_front();
                check("ack_cycle", cyc_cnt, e.cyc);
                check("ack_data", wb.WBs_RD_DAT, e.data);
            end
        end else if (wb.WBs_ACK !== 1'b0) begin
            n_checks++;
            $display("FAIL ack_unknown: got %b expected 0 or 1", wb.WBs_ACK);
        end
        if (sb_q.size() > 0 && cyc_cnt > sb_q[0].cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            $display("FAIL missed_ack: got none by cycle %0d, expected at %0d", cyc_cnt, e.cyc);
        end
    end

    // -----------------------------------------------------------------------
    // One bridge access.
    //   ack_lat: cycle the addressed client raises ACK (-1 = never)
    //   drop_at: cycle the master drops CYC (-1 = never)
    //   clr_at : cycle Tmo_Clr_i is pulsed (-1 = never)
    // -----------------------------------------------------------------------
    task automatic do_access(input logic [16:0] adr, input int ack_lat,
                             input int drop_at, input int clr_at);
        int          chn;
        bit          mapped;
        bit          tmo;
        bit          dropped;
        bit          gone;
        int          ack_cyc;
        int          last;
        int          cnt;
        int unsigned start;
        logic [127:0] lanes;
        logic [31:0]  exp_data;
        logic [3:0]   exp_cyc;
        exp_t         e;

        chn    = int'(adr[16:12]);
        mapped = (chn < NUM_CH);
        for (int l = 0; l < 4; l++) lanes[l*32 +: 32] = $urandom;

        // A client answering inside the window wins; anything else ends in
        // the default ACK one cycle after the window closes.
        if (mapped && ack_lat >= 0 && ack_lat <= TMO) begin
            tmo = 1'b0; ack_cyc = ack_lat;
        end else begin
            tmo = 1'b1; ack_cyc = TMO + 1;
        end
        // The default ACK is already committed once the window closes, so a
        // drop only cancels it if it happens within the window.
        dropped  = (drop_at >= 0) && (tmo ? (drop_at <= TMO) : (drop_at <= ack_lat));
        last     = dropped ? TMO + 3 : ack_cyc;
        exp_data = tmo ? DEF : lanes[chn*32 +: 32];

        cnt = tmo_model;
        if (!dropped && tmo) begin
            if (clr_at >= 0 && clr_at < ack_cyc) cnt = 0;
            cnt = (cnt == 255) ? 255 : cnt + 1;
            if (clr_at == ack_cyc) cnt = 0;
        end else if (clr_at >= 0 && clr_at <= last) begin
            cnt = 0;
        end

        @(posedge clk); #1;
        start = cyc_cnt;
        wb.WBs_ADR = adr;
        wb.WBs_CYC = 1'b1;
        wb.WBs_STB = 1'b1;
        ch_rd      = lanes;
        if (!dropped) begin
            e.cyc  = start + $unsigned(ack_cyc);
            e.data = exp_data;
            sb_q.push_back(e);
        end

        for (int c = 0; c <= last; c++) begin
            gone    = (drop_at >= 0) && (c >= drop_at);
            ch_ack  = (mapped && c == ack_lat) ? (4'b0001 << chn) : 4'b0000;
            tmo_clr = (c == clr_at);
            if (gone) wb.WBs_CYC = 1'b0;
            @(negedge clk);
            exp_cyc = (mapped && !gone && !(tmo && c == TMO + 1)) ? (4'b0001 << chn) : 4'b0000;
            check("ch_cyc", 32'(ch_cyc), 32'(exp_cyc));
            @(posedge clk); #1;
        end

        wb.WBs_CYC = 1'b0;
        wb.WBs_STB = 1'b0;
        ch_ack     = '0;
        tmo_clr    = 1'b0;
        tmo_model  = cnt;
        @(negedge clk);
        check("tmo_cnt", 32'(tmo_cnt), 32'(tmo_model));
    endtask

    // -----------------------------------------------------------------------
    // Interrupt folding on both instances: unchanged before the edge,
    // updated one cycle after.
    // -----------------------------------------------------------------------
    task automatic intr_check(input logic [3:0] i4, input logic [5:0] i6);
        logic [3:0] e4;
        logic [3:0] e6;
        e4 = '0;
        e6 = '0;
        for (int i = 0; i < 4; i++) if (i4[i]) e4[i % 4] = 1'b1;
        for (int i = 0; i < 6; i++) if (i6[i]) e6[i % 4] = 1'b1;

        @(posedge clk); #1;
        ch_intr = i4;
        intr6   = i6;
        @(negedge clk);
        check("fb_before_edge", 32'(fb), 32'(fb_model4));
        check("fb6_before_edge", 32'(fb6), 32'(fb_model6));
        @(negedge clk);
        check("fb", 32'(fb), 32'(e4));
        check("fb6", 32'(fb6), 32'(e6));
        check("ch6_idle_cyc", 32'(cyc6), 32'd0);
        check("ch6_idle_ack", 32'(wb6.WBs_ACK), 32'd0);
        check("ch6_rd_lane0", wb6.WBs_RD_DAT, rd6[31:0]);
        check("ch6_tmo", 32'(tmo6), 32'd0);
        fb_model4 = e4;
        fb_model6 = e6;
    endtask

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int unsigned start;
        exp_t        e;

        rst        = 1'b1;
        wb.WBs_ADR = '0;
        wb.WBs_CYC = 1'b0;
        wb.WBs_STB = 1'b0;
        ch_ack     = '0;
        ch_rd      = '0;
        ch_intr    = '0;
        tmo_clr    = 1'b0;
        wb6.WBs_ADR = '0;
        wb6.WBs_CYC = 1'b0;
        wb6.WBs_STB = 1'b0;
        ack6       = '0;
        rd6        = '0;
        rd6[31:0]  = 32'h1234_5678;
        intr6      = '0;
        clr6       = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(wb.WBs_ACK), 32'd0);
        check("rst_ch_cyc", 32'(ch_cyc), 32'd0);
        check("rst_rd_dat", wb.WBs_RD_DAT, DEF);
        check("rst_tmo", 32'(tmo_cnt), 32'd0);
        check("rst_fb", 32'(fb), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed accesses
        do_access(17'h01000, 1, -1, -1);   // ch1 ACKs on 2nd cycle
        do_access(17'h02004, 0, -1, -1);   // ch2 zero-latency ACK
        do_access(17'h05000, -1, -1, -1);  // unmapped -> default ACK
        do_access(17'h1F000, 0, -1, -1);   // top of address space, unmapped

        // Saturation of the event counter, then a standalone clear
        for (int n = 0; n < 300; n++) do_access(17'h00000, -1, -1, -1);
        check("tmo_saturated", 32'(tmo_cnt), 32'd255);
        @(posedge clk); #1;
        tmo_clr = 1'b1;
        @(posedge clk); #1;
        tmo_clr   = 1'b0;
        tmo_model = 0;
        @(negedge clk);
        check("tmo_cleared", 32'(tmo_cnt), 32'd0);

        // Boundary cases
        do_access(17'h03000, TMO, -1, -1);      // ch3 ACK on the compare cycle
        do_access(17'h01000, TMO + 1, -1, -1);  // ch1 ACK during dflt_ack: ignored
        do_access(17'h02000, -1, 4, -1);        // master drops CYC at cycle 4
        do_access(17'h02000, -1, -1, -1);       // next access restarts at tmr=0
        do_access(17'h00000, -1, -1, TMO + 1);  // clear coincides with increment

        // Back-to-back: request held across two default ACKs
        @(posedge clk); #1;
        start      = cyc_cnt;
        wb.WBs_ADR = 17'h07000;
        wb.WBs_CYC = 1'b1;
        wb.WBs_STB = 1'b1;
        e.data = DEF;
        e.cyc  = start + TMO + 1;       sb_q.push_back(e);
        e.cyc  = start + 2 * (TMO + 1) + 1; sb_q.push_back(e);
        repeat (2 * (TMO + 1) + 2) @(posedge clk);
        #1;
        wb.WBs_CYC = 1'b0;
        wb.WBs_STB = 1'b0;
        tmo_model  = tmo_model + 2;
        @(negedge clk);
        check("tmo_back_to_back", 32'(tmo_cnt), 32'(tmo_model));

        // Interrupt folding
        intr_check(4'b1000, 6'b100000);
        intr_check(4'b0000, 6'b010001);
        for (int n = 0; n < 20; n++) intr_check(4'($urandom), 6'($urandom));

        // Reset in mid-access, with interrupts and counter non-zero
        intr_check(4'b0101, 6'b110000);
        do_access(17'h00000, -1, -1, -1);
        @(posedge clk); #1;
        wb.WBs_ADR = 17'h00000;
        wb.WBs_CYC = 1'b1;
        wb.WBs_STB = 1'b1;
        ch_rd[31:0] = 32'hCAFE_0000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("rst_mid_ack", 32'(wb.WBs_ACK), 32'd0);
            check("rst_mid_ch_cyc", 32'(ch_cyc), 32'd0);
            check("rst_mid_rd_dat", wb.WBs_RD_DAT, DEF);
            if (c > 0) begin
                check("rst_mid_tmo", 32'(tmo_cnt), 32'd0);
                check("rst_mid_fb", 32'(fb), 32'd0);
                check("rst_mid_fb6", 32'(fb6), 32'd0);
            end
            @(posedge clk); #1;
            if (c == 10) begin
                ch_intr = '0;
                intr6   = '0;
            end
        end
        wb.WBs_CYC = 1'b0;
        wb.WBs_STB = 1'b0;
        rst        = 1'b0;
        tmo_model  = 0;
        fb_model4  = '0;
        fb_model6  = '0;

        // Randomized accesses
        for (int n = 0; n < 80; n++) begin
            logic [4:0]  ch;
            logic [11:0] off;
            int          lat;
            int          drop;
            int          clr;
            ch   = 5'($urandom_range(0, 7));
            off  = 12'($urandom);
            lat  = $urandom_range(0, 11);
            if (lat >= 10) lat = -1;
            drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : -1;
            clr  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, TMO + 1)) : -1;
            do_access({ch, off}, lat, drop, clr);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
